// File: rtl/nv_ddre_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nv_ddre_arbiter
// Brief    : Round-robin two-port front end for the nv_ddre array; serialises
//            requests into command words and schedules power-cycle refresh.
// Revision : 1.0 - initial release
// ============================================================================
module nv_ddre_arbiter #(
    parameter int REFRESH_INTERVAL = 256,
    parameter int REFRESH_CYCLES   = 2,
    parameter int READ_LAT         = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic        a_req_write,
    input  logic [7:0]  a_req_addr,
    input  logic [7:0]  a_req_wdata,
    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic        b_req_write,
    input  logic [7:0]  b_req_addr,
    input  logic [7:0]  b_req_wdata,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic [17:0] mem_user_data,
    output logic        mem_enable,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic        mem_power_enable,
    input  logic [7:0]  mem_user_out
);

    localparam int c_cnt_w = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int c_rc_w  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int c_rl_w  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_INTERVAL - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_rc_w-1:0]  c_rc_max  = c_rc_w'(REFRESH_CYCLES - 1);
    localparam logic [c_rc_w-1:0]  c_rc_one  = c_rc_w'(1);
    localparam logic [c_rl_w-1:0]  c_rl_max  = c_rl_w'(READ_LAT - 1);
    localparam logic [c_rl_w-1:0]  c_rl_one  = c_rl_w'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RD_WAIT = 2'd2,
        S_REFRESH = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_rc_w-1:0]   r_rcnt;
    logic [c_rl_w-1:0]   r_lcnt;
    logic                r_last_grant;
    logic                r_write;
    logic                r_id;

    logic                w_refresh_due;
    logic                w_grant_a;
    logic                w_grant_b;
    logic                w_open;
    logic                w_sel_b;
    logic                w_write;
    logic [7:0]          w_addr;
    logic [7:0]          w_wdata;

    assign w_refresh_due = (r_cnt == c_cnt_max);

    // On a tie the port that did not win last time is granted.
    assign w_grant_a = a_req_valid && (!b_req_valid || r_last_grant);
    assign w_grant_b = b_req_valid && (!a_req_valid || !r_last_grant);
    assign w_open    = !rst && (r_state == S_IDLE) && !w_refresh_due;

    assign a_req_ready = w_open && w_grant_a;
    assign b_req_ready = w_open && w_grant_b;

    assign w_sel_b = b_req_ready;
    assign w_write = w_sel_b ? b_req_write : a_req_write;
    assign w_addr  = w_sel_b ? b_req_addr  : a_req_addr;
    assign w_wdata = w_sel_b ? b_req_wdata : a_req_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == S_IDLE) && w_refresh_due) begin
            r_cnt <= '0;
        end else if ((r_state != S_REFRESH) && !w_refresh_due) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_rcnt           <= '0;
            r_lcnt           <= '0;
            r_last_grant     <= 1'b1;
            r_write          <= 1'b0;
            r_id             <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_id           <= 1'b0;
            rsp_data         <= 8'h00;
            mem_user_data    <= 18'h0;
            mem_enable       <= 1'b0;
            mem_wr_en        <= 1'b0;
            mem_rd_en        <= 1'b0;
            mem_power_enable <= 1'b1;
        end else begin
            rsp_valid     <= 1'b0;
            mem_enable    <= 1'b0;
            mem_wr_en     <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_user_data <= 18'h0;
            case (r_state)
                S_IDLE: begin
                    if (w_refresh_due) begin
                        r_state          <= S_REFRESH;
                        r_rcnt           <= '0;
                        mem_power_enable <= 1'b0;
                    end else if (a_req_ready || b_req_ready) begin
                        // Command word is staged here so the strobes land in ISSUE.
                        r_state       <= S_ISSUE;
                        r_write       <= w_write;
                        r_id          <= w_sel_b;
                        r_last_grant  <= w_sel_b;
                        mem_enable    <= 1'b1;
                        mem_wr_en     <= w_write;
                        mem_rd_en     <= !w_write;
                        mem_user_data <= {(w_write ? 2'b01 : 2'b10), w_addr,
                                          (w_write ? w_wdata : 8'h00)};
                    end
                end
                S_ISSUE: begin
                    if (r_write) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_RD_WAIT;
                        r_lcnt  <= '0;
                    end
                end
                S_RD_WAIT: begin
                    if (r_lcnt == c_rl_max) begin
                        r_state   <= S_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_id;
                        rsp_data  <= mem_user_out;
                    end else begin
                        r_lcnt <= r_lcnt + c_rl_one;
                    end
                end
                S_REFRESH: begin
                    if (r_rcnt == c_rc_max) begin
                        r_state          <= S_IDLE;
                        mem_power_enable <= 1'b1;
                    end else begin
                        r_rcnt <= r_rcnt + c_rc_one;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/nv_ddre_arbiter.md
# nv_ddre_arbiter

Two-requester front end for the `nv_ddre` non-volatile DDR array. It arbitrates round-robin between ports A and B and serialises their accepted read/write requests into the memory's 18-bit command word and strobes. It also schedules periodic power-cycle refresh windows by deasserting `power_enable`. It sits between the user-side masters and the `nv_ddre` instance and returns read data tagged with the requester id.

## Interface
Parameters:
- `REFRESH_INTERVAL`, 256: cycles between refresh windows, ≥ 8.
- `REFRESH_CYCLES`, 2: cycles `mem_power_enable` is held low per window, ≥ 1.
- `READ_LAT`, 1: cycles from the memory read strobe to valid `mem_user_out`, ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `a_req_valid` in 1: port A request valid.
- `a_req_ready` out 1: port A request accepted this cycle.
- `a_req_write` in 1: 1 = write, 0 = read.
- `a_req_addr` in 8: [7:4] row, [3:0] column.
- `a_req_wdata` in 8: write data.
- `b_req_valid`, `b_req_ready`, `b_req_write`, `b_req_addr`, `b_req_wdata`: same as port A, for port B.
- `rsp_valid` out 1: one-cycle read-data pulse.
- `rsp_id` out 1: 0 = A, 1 = B.
- `rsp_data` out 8: read data.
- `mem_user_data` out 18: {cmd[1:0], row[3:0], col[3:0], data[7:0]}; cmd 2'b01 = write, 2'b10 = read.
- `mem_enable` out 1, `mem_wr_en` out 1, `mem_rd_en` out 1: memory strobes.
- `mem_power_enable` out 1: 0 during refresh windows.
- `mem_user_out` in 8: memory read data.

## Operation
- FSM states: IDLE, ISSUE, RD_WAIT, REFRESH. Reset state is IDLE.
- Refresh counter:
  - Increments every cycle outside REFRESH.
  - At `REFRESH_INTERVAL-1` it saturates and sets `refresh_due`.
  - It clears on REFRESH entry.
- IDLE:
  - If `refresh_due`, go to REFRESH. Refresh beats new grants.
  - Otherwise arbitrate among valid requesters and grant one. The granted port's `*_req_ready` = 1, combinationally from valid, state and `last_grant`.
  - On the handshake, latch write, addr, wdata and id, update `last_grant`, and go to ISSUE.
- Arbitration:
  - Single valid requester wins.
  - If both are valid, the port ≠ `last_grant` wins.
  - `last_grant` resets to B, so A wins the first tie.
- ISSUE, one cycle:
  - `mem_enable` = 1.
  - Write: `mem_wr_en` = 1, cmd 01, data = wdata; next state IDLE.
  - Read: `mem_rd_en` = 1, cmd 10, data = 0; next state RD_WAIT.
- RD_WAIT:
  - Lasts `READ_LAT` cycles.
  - On its last cycle, capture `mem_user_out` into `rsp_data` and set `rsp_id`.
  - Pulse `rsp_valid` for the following cycle; next state IDLE.
- REFRESH:
  - `mem_power_enable` = 0 for `REFRESH_CYCLES` cycles, then IDLE.
  - Both ready outputs are 0.
  - An in-flight ISSUE or RD_WAIT always completes before REFRESH is entered; `refresh_due` only takes effect in IDLE.
- Outside ISSUE, `mem_enable`, `mem_wr_en`, `mem_rd_en` = 0 and `mem_user_data` = 0.
- All `mem_*` and `rsp_*` outputs are registered.

## Timing
- Reset values:
  - All `mem_*` = 0 except `mem_power_enable` = 1.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0.
  - Both ready outputs = 0 while `rst` is high.
  - Refresh counter = 0.
- Handshake in cycle t: strobes are high in cycle t+1.
- Read:
  - `mem_user_out` is sampled at the end of cycle t+1+READ_LAT.
  - `rsp_valid` is high in cycle t+2+READ_LAT.
- Next grant possible:
  - Write: cycle t+2.
  - Read: cycle t+2+READ_LAT, the same cycle `rsp_valid` is high.
- Refresh: `refresh_due` set while IDLE → `mem_power_enable` low from the next cycle for exactly `REFRESH_CYCLES` cycles.
- Request held under refresh: stays pending (`valid` must stay high) and is granted in the first IDLE cycle after REFRESH.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately (asynchronous).
  - A pending read is dropped with no `rsp_valid`.
  - `mem_power_enable` returns to 1 even mid-refresh.

## Test plan
- Single write then read, READ_LAT=1:
  - Stimulus: A writes addr 0x23, data 0x17.
  - Required: `mem_user_data` = 18'b01_0010_0011_00010111 with `mem_wr_en` for one cycle.
  - Then A reads 0x23; memory model returns 0x17.
  - Required: `rsp_valid` with `rsp_id` = 0, `rsp_data` = 0x17, exactly 3 cycles after the handshake.
- Contention: A and B both hold valid writes for 4 grants.
  - Required: grant order A, B, A, B; each ready is high for exactly one cycle per grant.
- Refresh preemption, REFRESH_INTERVAL=8, REFRESH_CYCLES=2:
  - Stimulus: continuous A writes.
  - Required: after the in-flight write completes, `mem_power_enable` is low for 2 cycles with `a_req_ready` = 0; then grants resume.
- Refresh during read, READ_LAT=3:
  - Stimulus: `refresh_due` is set during RD_WAIT.
  - Required: `rsp_valid` is delivered first; `mem_power_enable` falls the cycle after IDLE is re-entered.
- Reset mid-read:
  - Stimulus: assert `rst` during RD_WAIT.
  - Required: `rsp_valid` never pulses; all outputs hold reset values; after release, the first tie is granted to A.
